seq_mult_mxn: RTL and testbench
===============================

SEQ_MULT_MXN -- requirements
Module: seq_mult_mxn

Interface
REQ-001 SHALL have parameter M, default 16, multiplicand width in bits; legal values are multiples of 4 and at least 4.
REQ-002 SHALL have parameter N, default 16, multiplier width in bits; legal values are at least 1.
REQ-003 SHALL have parameter EARLY_TERM, default 0; when 1, the block finishes early once the remaining multiplicand nibbles are all zero.
REQ-004 clk  input  1  sole clock; all flops update on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operands a, b are valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a  input  M  multiplicand, unsigned.
REQ-009 b  input  N  multiplier, unsigned.
REQ-010 out_valid  output  1  p holds a finished product.
REQ-011 out_ready  input  1  consumer accepts p.
REQ-012 p  output  M+N  product a*b, unsigned, full width.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CALC, HOLD.
REQ-014 IDLE: in_ready=1 and out_valid=0; when in_valid=1 at a rising edge, SHALL capture a and b, clear the accumulator and nibble counter k, and go to CALC.
REQ-015 CALC: in_ready=0; each cycle SHALL add (a_reg[4k+3:4k] * b_reg) << 4k to the M+N-bit accumulator, then increment k, processing LSB nibble first.
REQ-016 CALC SHALL go to HOLD after the edge that processes nibble k=M/4-1, so out_valid rises exactly M/4 cycles after the accept edge.
REQ-017 With EARLY_TERM=1, CALC SHALL go to HOLD after the edge where a_reg[M-1:4(k+1)] is zero, and SHALL never exceed M/4 cycles.
REQ-018 HOLD: out_valid=1, in_ready=0; p and out_valid SHALL stay stable while out_ready=0.
REQ-019 HOLD: when out_ready=1 at an edge, SHALL go to IDLE; the next accept is possible one cycle later at the earliest.
REQ-020 in_valid SHALL be ignored in CALC and HOLD; operands are not queued.
REQ-021 The accumulator SHALL be exactly M+N bits wide and never overflow; (2^M-1)*(2^N-1) fits.
REQ-022 p SHALL be driven directly from the accumulator register; out_valid, in_ready and p SHALL be glitch-free (registered or pure state decode).
REQ-023 a=0 or b=0 SHALL yield p=0, with the same latency as REQ-016/017.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, with in_ready=1, out_valid=0, p=0, k=0 and operand registers cleared.
REQ-025 Reset asserted in CALC or HOLD SHALL abort the operation with no output handshake; the product is discarded.
REQ-026 After rst_n deasserts, the first accept edge SHALL behave exactly as in REQ-014.

Structure
REQ-027 A shared package seq_mult_pkg SHALL hold the state typedef (IDLE/CALC/HOLD) and a constant function for counter width, clog2(M/4) with a minimum of 1.
REQ-028 The nibble partial product SHALL use one instance of the existing combinational Multiplier_4xN (parameter n=N), fed with the selected nibble and b_reg.
REQ-029 There SHALL be no other sub-modules; the shifter, adder, counter and FSM live in seq_mult_mxn.

Verification
REQ-030 M=16, N=16, a=0xFFFF, b=0xFFFF, out_ready=1 -> out_valid exactly 4 cycles after accept, p=0xFFFE0001.
REQ-031 M=16, N=16, EARLY_TERM=1, a=0x0003, b=0x1234 -> out_valid 1 cycle after accept, p=0x369C; with EARLY_TERM=0 -> 4 cycles, same p.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in HOLD -> p and out_valid stable and in_ready=0 throughout; out_ready=1 -> IDLE on the next cycle.
REQ-033 Reset pulse in the 2nd CALC cycle -> in_ready=1, out_valid=0, p=0 immediately; a following a=5, b=7 -> p=35.
REQ-034 Randomised sweep: M=8, N=12, all a and 256 random b, back-to-back in_valid -> every p equals a*b, and no accept occurs while in_ready=0.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the nibble-serial M x N multiplier.
package seq_mult_pkg;

    // Controller states: waiting for operands, accumulating nibbles, presenting the product.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Width of the nibble counter for an m-bit multiplicand: clog2(m/4), never below 1.
    function automatic int cnt_width(input int m);
        int w;
        w = $clog2(m / 4);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/Multiplier_4xN.sv
// Combinational 4-bit by n-bit unsigned multiplier producing the full n+4 bit product.
module Multiplier_4xN #(
    parameter int n = 16
) (
    input  logic [3:0]   a,
    input  logic [n-1:0] b,
    output logic [n+3:0] p
);

    // Both operands are zero-extended to the product width so no bits are lost.
    assign p = {{n{1'b0}}, a} * {4'b0000, b};

endmodule

// File: rtl/seq_mult_mxn.sv
// Sequential unsigned multiplier: one multiplicand nibble per cycle, LSB nibble first,
// with a valid/ready handshake on both the operand and the product side.
module seq_mult_mxn
    import seq_mult_pkg::*;
#(
    parameter int M          = 16,
    parameter int N          = 16,
    parameter int EARLY_TERM = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M+N-1:0] p
);

    localparam int NIB = M / 4;
    localparam int KW  = cnt_width(M);
    localparam int PW  = M + N;
    localparam logic [KW-1:0] LAST_K = KW'(NIB - 1);

    state_t          state_q;
    logic [M-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   k_d;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   acc_d;
    logic            in_ready_q;
    logic            out_valid_q;

    logic [M-1:0]    a_shift;
    logic [3:0]      nib;
    logic [N+3:0]    pp;
    logic [PW-1:0]   pp_shift;
    logic            last_nib;

    // One nibble partial product per cycle.
    Multiplier_4xN #(
        .n (N)
    ) u_mult (
        .a (nib),
        .b (b_q),
        .p (pp)
    );

    // Select the current nibble, align its partial product and decide whether this is the final step.
    // NOTE: every signal assigned in always_comb gets a value at the top so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        a_shift  = a_q >> {k_q, 2'b00};
        nib      = a_shift[3:0];
        pp_shift = PW'(pp) << {k_q, 2'b00};
        acc_d    = acc_q + pp_shift;
        k_d      = k_q + KW'(1);
        last_nib = (k_q == LAST_K);
        // Nothing left above the current nibble: further steps would only add zero.
        if ((EARLY_TERM != 0) && ((a_shift >> 4) == '0)) begin
            last_nib = 1'b1;
        end
    end

    // Control FSM with registered handshake outputs and the datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand registers are reset too, so an aborted operation leaves no stale data behind.
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        k_q        <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    k_q   <= k_d;
                    if (last_nib) begin
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = acc_q;

endmodule

// File: tb/tb_seq_mult_mxn.sv
// Self-checking bench for seq_mult_mxn: three configurations checked every cycle against
// a transaction-level model, plus hand-computed expectations for the key scenarios.
module tb_seq_mult_mxn;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Stimulus per instance: 0 = M16/N16, 1 = M16/N16 early-term, 2 = M8/N12.
    logic        iv   [3];
    logic        ordy [3];
    logic [31:0] a_w  [3];
    logic [31:0] b_w  [3];

    logic        ir0, ir1, ir2, ov0, ov1, ov2;
    logic [31:0] p0, p1;
    logic [19:0] p2;
    logic        ir [3];
    logic        ov [3];
    logic [31:0] pv [3];

    seq_mult_mxn #(.M(16), .N(16), .EARLY_TERM(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
        .a(a_w[0][15:0]), .b(b_w[0][15:0]), .out_valid(ov0), .out_ready(ordy[0]), .p(p0)
    );
    seq_mult_mxn #(.M(16), .N(16), .EARLY_TERM(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
        .a(a_w[1][15:0]), .b(b_w[1][15:0]), .out_valid(ov1), .out_ready(ordy[1]), .p(p1)
    );
    seq_mult_mxn #(.M(8), .N(12), .EARLY_TERM(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2),
        .a(a_w[2][7:0]), .b(b_w[2][11:0]), .out_valid(ov2), .out_ready(ordy[2]), .p(p2)
    );

    always_comb begin
        ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
        ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
        pv[0] = p0;  pv[1] = p1;  pv[2] = {12'b0, p2};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cfg_m(input int i);
        return (i == 2) ? 8 : 16;
    endfunction

    function automatic int cfg_n(input int i);
        return (i == 2) ? 12 : 16;
    endfunction

    // Cycles from accept to out_valid: all nibbles, or up to the highest non-zero nibble (min 1) with early termination.
    function automatic int exp_lat(input int i, input logic [31:0] av);
        int hi;
        if (i != 1) return cfg_m(i) / 4;
        hi = 1;
        for (int j = 0; j < 4; j++) begin
            if (((av >> (4 * j)) & 32'hF) != 0) hi = j + 1;
        end
        return hi;
    endfunction

    // Transaction-level model: accept, wait the expected latency, present a*b until taken.
    bit          m_ready [3];
    bit          m_valid [3];
    int          m_cnt   [3];
    logic [31:0] m_exp   [3];
    logic [31:0] m_p     [3];
    int          acc_cnt [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_ready[i] <= 1'b1;
                m_valid[i] <= 1'b0;
                m_cnt[i]   <= 0;
                m_p[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_ready[i] && iv[i]) begin
                    logic [63:0] ma, mb;
                    ma = 64'(a_w[i]) & ((64'd1 << cfg_m(i)) - 1);
                    mb = 64'(b_w[i]) & ((64'd1 << cfg_n(i)) - 1);
                    m_ready[i] <= 1'b0;
                    m_exp[i]   <= 32'(ma * mb);
                    m_cnt[i]   <= exp_lat(i, a_w[i]);
                    acc_cnt[i] <= acc_cnt[i] + 1;
                end else if (m_cnt[i] > 0) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) begin
                        m_valid[i] <= 1'b1;
                        m_p[i]     <= m_exp[i];
                    end
                end else if (m_valid[i] && ordy[i]) begin
                    m_valid[i] <= 1'b0;
                    m_ready[i] <= 1'b1;
                end
            end
        end
    end

    // Compare DUT handshake and product against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("cyc_in_ready[%0d]", i), 64'(ir[i]), 64'(m_ready[i]));
                check($sformatf("cyc_out_valid[%0d]", i), 64'(ov[i]), 64'(m_valid[i]));
                if (m_valid[i]) check($sformatf("cyc_p[%0d]", i), 64'(pv[i]), 64'(m_p[i]));
            end
        end
    end

    // Present operands, wait (bounded) for the accept edge, then count cycles until out_valid.
    task automatic do_op(input int i, input logic [31:0] av, input logic [31:0] bv,
                         output int lat, output logic [31:0] prod);
        int start, guard;
        a_w[i] = av;
        b_w[i] = bv;
        iv[i]  = 1'b1;
        start  = acc_cnt[i];
        guard  = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (acc_cnt[i] == start && guard < 50);
        if (guard >= 50) check("accept_timeout", 64'(guard), 64'd0);
        iv[i] = 1'b0;
        lat = 0;
        while (!ov[i] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        prod = pv[i];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] prod;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; a_w[i] = '0; b_w[i] = '0; acc_cnt[i] = 0;
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(ir0), 64'd1);
        check("rst_out_valid", 64'(ov0), 64'd0);
        check("rst_p", 64'(p0), 64'd0);
        check("rst_p_m8", 64'(p2), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Largest operands, full latency.
        do_op(0, 32'hFFFF, 32'hFFFF, lat, prod);
        check("max_lat", 64'(lat), 64'd4);
        check("max_p", 64'(prod), 64'hFFFE0001);

        // Early termination versus full run on the same operands.
        do_op(1, 32'h0003, 32'h1234, lat, prod);
        check("et_lat", 64'(lat), 64'd1);
        check("et_p", 64'(prod), 64'h369C);
        do_op(0, 32'h0003, 32'h1234, lat, prod);
        check("noet_lat", 64'(lat), 64'd4);
        check("noet_p", 64'(prod), 64'h369C);

        // Zero operands and early-term at intermediate nibbles.
        do_op(1, 32'h0000, 32'hABCD, lat, prod);
        check("et_a0_lat", 64'(lat), 64'd1);
        check("et_a0_p", 64'(prod), 64'd0);
        do_op(0, 32'h1234, 32'h0000, lat, prod);
        check("b0_lat", 64'(lat), 64'd4);
        check("b0_p", 64'(prod), 64'd0);
        do_op(1, 32'h0F00, 32'h0003, lat, prod);
        check("et_n2_lat", 64'(lat), 64'd3);
        check("et_n2_p", 64'(prod), 64'h2D00);
        do_op(1, 32'hF000, 32'h0002, lat, prod);
        check("et_n3_lat", 64'(lat), 64'd4);
        check("et_n3_p", 64'(prod), 64'h1E000);

        // Backpressure: product held, new operands ignored, release returns to IDLE next cycle.
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        do_op(0, 32'h1234, 32'h5678, lat, prod);
        check("bp_lat", 64'(lat), 64'd4);
        a_w[0] = 32'h1; b_w[0] = 32'h1; iv[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(ov0), 64'd1);
            check("bp_ready", 64'(ir0), 64'd0);
            check("bp_p", 64'(p0), 64'h06260060);
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_rel_ready", 64'(ir0), 64'd1);
        check("bp_rel_valid", 64'(ov0), 64'd0);

        // Reset during the second CALC cycle aborts the operation immediately.
        @(posedge clk); #1;
        a_w[0] = 32'hFFFF; b_w[0] = 32'hFFFF; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        check("abort_busy", 64'(ir0), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(ir0), 64'd1);
        check("abort_valid", 64'(ov0), 64'd0);
        check("abort_p", 64'(p0), 64'd0);
        #2;
        rst_n = 1'b1;
        do_op(0, 32'd5, 32'd7, lat, prod);
        check("post_rst_lat", 64'(lat), 64'd4);
        check("post_rst_p", 64'(prod), 64'd35);

        // Sweep on M=8/N=12: every a with a random b, in_valid held high back-to-back.
        @(posedge clk); #1;
        iv[2] = 1'b1;
        for (int av = 0; av < 256; av++) begin
            int start, guard;
            a_w[2] = 32'(av);
            b_w[2] = 32'($urandom_range(0, 4095));
            start  = acc_cnt[2];
            guard  = 0;
            do begin
                @(posedge clk); #1;
                guard++;
            end while (acc_cnt[2] == start && guard < 50);
            if (guard >= 50) check("sweep_accept_timeout", 64'(guard), 64'd0);
        end
        iv[2] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("sweep_accepts", 64'(acc_cnt[2]), 64'd256);
        check("sweep_idle", 64'(ir2), 64'd1);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
